// File: rtl/fc_pipe_param.sv
// Streaming fully-connected layer y = sat(W*x) with double-buffered x storage.
// Optional build macro FC_PIPE_RELU_EN clamps negative row results to zero.
module fc_pipe_param #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int T = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        input_valid,
  output logic                        input_ready,
  input  logic signed [T-1:0]         input_data,
  output logic [$clog2(M*N)-1:0]      w_addr,
  input  logic signed [T-1:0]         w_data,
  output logic                        output_valid,
  input  logic                        output_ready,
  output logic signed [T-1:0]         output_data
);
  localparam int AW = $clog2(M*N);
  localparam int CW = $clog2(N);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int XW = $clog2(2*N);
  localparam logic signed [2*T-1:0] MAX_W = {{(T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [2*T-1:0] MIN_W = {{(T+1){1'b1}}, {(T-1){1'b0}}};

  typedef enum logic {FILL, FULL_WAIT} ld_state_t;
  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} cp_state_t;

  ld_state_t          ld_state_reg, ld_state_next;
  logic               ld_bank_reg, ld_bank_next;
  logic [CW-1:0]      ld_idx_reg, ld_idx_next;
  logic [1:0]         full_reg, full_next;
  logic               ready_reg;
  logic               accept, load_done, release_bank;

  cp_state_t          cp_state_reg, cp_state_next;
  logic               cp_bank_reg, cp_bank_next;
  logic [RW-1:0]      row_reg, row_next;
  logic [CW-1:0]      col_reg, col_next;
  logic               drain_reg, drain_next;
  logic               acc_clear;
  logic               v1_reg, v2_reg;
  logic signed [T-1:0] x_reg, prod_reg, acc_reg, out_val;
  logic [XW-1:0]      wr_addr, rd_addr;

  logic signed [T-1:0] xmem [2*N];

  function automatic logic signed [T-1:0] sat(input logic signed [2*T-1:0] v);
    if (v > MAX_W) return MAX_W[T-1:0];
    if (v < MIN_W) return MIN_W[T-1:0];
    return v[T-1:0];
  endfunction

  // Load engine: a bank freed this cycle counts as free, so ready returns next cycle.
  always_comb begin
    accept        = input_valid && ready_reg;
    load_done     = accept && (ld_idx_reg == CW'(N-1));
    release_bank  = (cp_state_reg == OUT) && output_ready && (row_reg == RW'(M-1));
    full_next     = full_reg;
    if (release_bank) full_next[cp_bank_reg] = 1'b0;
    if (load_done)    full_next[ld_bank_reg] = 1'b1;
    ld_state_next = ld_state_reg;
    ld_bank_next  = ld_bank_reg;
    ld_idx_next   = ld_idx_reg;
    case (ld_state_reg)
      FILL: begin
        if (load_done) begin
          ld_idx_next   = '0;
          ld_bank_next  = ~ld_bank_reg;
          ld_state_next = full_next[~ld_bank_reg] ? FULL_WAIT : FILL;
        end else if (accept) begin
          ld_idx_next = ld_idx_reg + 1'b1;
        end
      end
      FULL_WAIT: if (!full_next[ld_bank_reg]) ld_state_next = FILL;
      default:   ld_state_next = FILL;
    endcase
  end

  // Compute engine: banks are consumed in the same alternating order they were filled.
  always_comb begin
    cp_state_next = cp_state_reg;
    cp_bank_next  = cp_bank_reg;
    row_next      = row_reg;
    col_next      = col_reg;
    drain_next    = drain_reg;
    acc_clear     = 1'b0;
    case (cp_state_reg)
      IDLE: if (full_reg[cp_bank_reg]) begin
        cp_state_next = MAC;
        row_next      = '0;
        col_next      = '0;
        acc_clear     = 1'b1;
      end
      MAC: begin
        if (col_reg == CW'(N-1)) begin
          col_next      = '0;
          drain_next    = 1'b0;
          cp_state_next = DRAIN;
        end else begin
          col_next = col_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_reg) cp_state_next = OUT;
        else           drain_next    = 1'b1;
      end
      OUT: if (output_ready) begin
        if (row_reg == RW'(M-1)) begin
          cp_state_next = IDLE;
          cp_bank_next  = ~cp_bank_reg;
        end else begin
          row_next      = row_reg + 1'b1;
          cp_state_next = MAC;
          acc_clear     = 1'b1;
        end
      end
      default: cp_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state_reg <= FILL;
      ld_bank_reg  <= 1'b0;
      ld_idx_reg   <= '0;
      full_reg     <= '0;
      ready_reg    <= 1'b0;
      cp_state_reg <= IDLE;
      cp_bank_reg  <= 1'b0;
      row_reg      <= '0;
      col_reg      <= '0;
      drain_reg    <= 1'b0;
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      prod_reg     <= '0;
      acc_reg      <= '0;
    end else begin
      ld_state_reg <= ld_state_next;
      ld_bank_reg  <= ld_bank_next;
      ld_idx_reg   <= ld_idx_next;
      full_reg     <= full_next;
      ready_reg    <= (ld_state_next == FILL);
      cp_state_reg <= cp_state_next;
      cp_bank_reg  <= cp_bank_next;
      row_reg      <= row_next;
      col_reg      <= col_next;
      drain_reg    <= drain_next;
      v1_reg       <= (cp_state_reg == MAC);
      v2_reg       <= v1_reg;
      if (v1_reg)
        prod_reg <= sat($signed({{T{x_reg[T-1]}}, x_reg}) * $signed({{T{w_data[T-1]}}, w_data}));
      if (acc_clear)
        acc_reg <= '0;
      else if (v2_reg)
        acc_reg <= sat($signed({{T{acc_reg[T-1]}}, acc_reg}) + $signed({{T{prod_reg[T-1]}}, prod_reg}));
    end
  end

  assign wr_addr = XW'(ld_bank_reg ? N : 0) + XW'(ld_idx_reg);
  assign rd_addr = XW'(cp_bank_reg ? N : 0) + XW'(col_reg);

  // x storage has no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) xmem[wr_addr] <= input_data;
    if (cp_state_reg == MAC) x_reg <= xmem[rd_addr];
  end

  always_comb begin
    out_val = acc_reg;
`ifdef FC_PIPE_RELU_EN
    if (acc_reg[T-1]) out_val = '0;
`else
`endif
    output_data = (cp_state_reg == OUT) ? out_val : '0;
  end

  assign input_ready  = ready_reg;
  assign output_valid = (cp_state_reg == OUT);
  assign w_addr       = (cp_state_reg == MAC) ? AW'(int'(row_reg) * N + int'(col_reg)) : '0;

endmodule
